dead_time_gen: RTL and testbench
================================

# dead_time_gen

Multi-channel complementary gate-drive generator with programmable dead-time insertion for the BLDC inverter bridge. Each channel takes one PWM command and drives a high-side/low-side pair. The two outputs of a pair are never asserted together, and every side change passes through a programmable all-off interval. The block sits between the commutation/PWM logic and the gate-driver pins and replaces the single-pair dead-time stage.

## Interface
Parameters:
- N_CH, 3, number of half-bridge channels (1..8)
- DT_W, 8, width of the dead-time count (dead time up to 2^DT_W−1 cycles)

Ports (reset is asynchronous and active-high; all logic on rising CLK):
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- EN  in  1  global enable; 0 forces all channels OFF
- FAULT  in  1  bridge fault; forces all channels OFF, priority over EN
- PWM_IN  in  N_CH  per-channel command; 1 = high side, 0 = low side
- DT_CYCLES  in  DT_W  dead time in clock cycles, shared by all channels (present without DEAD_TIME_ASYM_EN)
- DT_RISE, DT_FALL  in  DT_W each  L→H and H→L dead times (present only with DEAD_TIME_ASYM_EN)
- PWM_H  out  N_CH  high-side gate drive, registered
- PWM_L  out  N_CH  low-side gate drive, registered
- DT_ACTIVE  out  N_CH  1 while the channel is in a dead interval, registered

## Operation
- Each channel runs an independent FSM with states OFF, DEAD_H (heading high), HS_ON, DEAD_L (heading low), LS_ON.
- Outputs per state:
  - OFF: H=0, L=0, DT_ACTIVE=0
  - DEAD_H / DEAD_L: H=0, L=0, DT_ACTIVE=1
  - HS_ON: H=1, L=0
  - LS_ON: H=0, L=1
- Kill: FAULT=1 or EN=0 → OFF on the next edge from any state, with the counter cleared.
- Leaving OFF (EN=1, FAULT=0): PWM_IN=1 → DEAD_H; PWM_IN=0 → DEAD_L. The full dead interval always applies.
- LS_ON with PWM_IN=1 → DEAD_H. HS_ON with PWM_IN=0 → DEAD_L.
- Dead-time counting:
  - On entry to a dead state the counter loads the dead time sampled on that edge (DT_CYCLES, or DT_RISE for DEAD_H / DT_FALL for DEAD_L).
  - A load value of 0 is treated as 1.
  - The counter decrements each cycle. The FSM exits to HS_ON (from DEAD_H) or LS_ON (from DEAD_L) on the edge where the counter equals 1.
  - Dead interval = max(DT,1) cycles with both outputs low.
- Command reversal mid-dead:
  - In DEAD_H with PWM_IN=0, go to LS_ON on the next edge; the pulse is swallowed and H never asserts.
  - DEAD_L with PWM_IN=1 likewise goes to HS_ON.
  - The opposite side was on before the dead interval started, so returning to it directly is shoot-through safe.
- Changes to DT inputs during a dead interval do not affect the interval in progress.
- Invariant: PWM_H[i] & PWM_L[i] == 0 in every cycle, including reset and kill.

## Timing
- Reset: all channels OFF; PWM_H=0, PWM_L=0, DT_ACTIVE=0; counters 0.
- PWM_IN is sampled on the rising edge. Taking the 0→1 command sampled at edge n (channel in LS_ON):
  - PWM_L falls after edge n and DT_ACTIVE rises.
  - PWM_H rises after edge n+max(DT,1).
- FAULT/EN: outputs low one cycle after the sampling edge; RST clears outputs asynchronously.
- No input synchronisers. PWM_IN, EN and FAULT are synchronous to CLK; an external FAULT must be synchronised upstream.

## Configuration
- DEAD_TIME_ASYM_EN defined: DT_RISE and DT_FALL ports exist. DT_RISE sets the DEAD_H interval and DT_FALL sets the DEAD_L interval, so the two bridge transitions can be tuned separately.
- DEAD_TIME_ASYM_EN undefined: the single DT_CYCLES port serves both directions and DT_RISE/DT_FALL are absent. Behaviour is otherwise identical.

## Structure
- Package dead_time_pkg holds:
  - the 3-bit state typedef/encoding (OFF, DEAD_H, HS_ON, DEAD_L, LS_ON)
  - the default DT_W constant
  - the N_CH upper-bound constant
- Sub-module dead_time_ch implements one channel (FSM, counter and registered outputs). The top level generates N_CH instances and fans out EN, FAULT and the DT inputs.

## Test plan
- Reset then EN=1, PWM_IN=000, DT=5 → all L go high 5 cycles after the first sampling edge, with DT_ACTIVE high for those 5 cycles; no H.
- Channel 0 in LS_ON, PWM_IN[0] 0→1, DT=5 → L[0] low next cycle, H[0] high 5 cycles later; 1→0 gives the mirrored timing.
- DT=0 and DT=1 → dead interval exactly 1 cycle in both cases. DT=255 → 255 cycles.
- 3-cycle high pulse on PWM_IN[1] with DT=8 → H[1] never asserts; L[1] is off for 3 cycles, then back on.
- FAULT=1 while all channels are in HS_ON → all outputs 0 one cycle later. After FAULT clears, each channel resumes via a full dead interval. Overlap checker (H&L) active throughout.
- With DEAD_TIME_ASYM_EN, DT_RISE=3, DT_FALL=7 → L→H dead interval 3 cycles, H→L dead interval 7 cycles.

Source files
------------

// File: rtl/dead_time_pkg.sv
// Shared definitions for the dead_time_gen codebase slice.
//   ch_state_t : per-channel FSM state encoding (3 bits)
//   DT_W_DEF   : default width of the dead-time count
//   N_CH_MAX   : largest supported number of half-bridge channels
package dead_time_pkg;

  localparam int unsigned DT_W_DEF = 8;
  localparam int unsigned N_CH_MAX = 8;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    DEAD_H = 3'd1,
    HS_ON  = 3'd2,
    DEAD_L = 3'd3,
    LS_ON  = 3'd4
  } ch_state_t;

endpackage

// File: rtl/dead_time_ch.sv
// One half-bridge channel: complementary drive with dead-time insertion.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_en, i_fault      global enable / bridge fault (fault wins); either kills to OFF
//   i_pwm              command, 1 = high side, 0 = low side
//   i_dt_rise          dead time for the L->H transition (DEAD_H)
//   i_dt_fall          dead time for the H->L transition (DEAD_L)
//   o_pwm_h, o_pwm_l   registered gate drives, never both 1
//   o_dt_active        registered, 1 while in a dead interval
module dead_time_ch
  import dead_time_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_fault,
  input  logic            i_pwm,
  input  logic [DT_W-1:0] i_dt_rise,
  input  logic [DT_W-1:0] i_dt_fall,
  output logic            o_pwm_h,
  output logic            o_pwm_l,
  output logic            o_dt_active
);

  ch_state_t       r_state;
  logic [DT_W-1:0] r_cnt;
  logic            r_h;
  logic            r_l;
  logic            r_dta;

  logic            w_kill;
  logic [DT_W-1:0] w_load_rise;
  logic [DT_W-1:0] w_load_fall;

  assign w_kill = i_fault | ~i_en;

  // A programmed dead time of 0 still yields a one-cycle all-off interval.
  assign w_load_rise = (i_dt_rise == '0) ? DT_W'(1) : i_dt_rise;
  assign w_load_fall = (i_dt_fall == '0) ? DT_W'(1) : i_dt_fall;

  // Channel FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_h     <= 1'b0;
      r_l     <= 1'b0;
      r_dta   <= 1'b0;
    end else if (w_kill) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_h     <= 1'b0;
      r_l     <= 1'b0;
      r_dta   <= 1'b0;
    end else begin
      case (r_state)
        OFF, LS_ON, HS_ON: begin
          // Start a dead interval whenever the command differs from the
          // side currently driven (OFF drives neither, so it always leaves).
          if (i_pwm && (r_state != HS_ON)) begin
            r_state <= DEAD_H;
            r_cnt   <= w_load_rise;
            r_h     <= 1'b0;
            r_l     <= 1'b0;
            r_dta   <= 1'b1;
          end else if (!i_pwm && (r_state != LS_ON)) begin
            r_state <= DEAD_L;
            r_cnt   <= w_load_fall;
            r_h     <= 1'b0;
            r_l     <= 1'b0;
            r_dta   <= 1'b1;
          end
        end
        DEAD_H: begin
          // Reversal returns straight to the side that was on before.
          if (!i_pwm) begin
            r_state <= LS_ON;
            r_cnt   <= '0;
            r_l     <= 1'b1;
            r_dta   <= 1'b0;
          end else if (r_cnt == DT_W'(1)) begin
            r_state <= HS_ON;
            r_cnt   <= '0;
            r_h     <= 1'b1;
            r_dta   <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - DT_W'(1);
          end
        end
        DEAD_L: begin
          if (i_pwm) begin
            r_state <= HS_ON;
            r_cnt   <= '0;
            r_h     <= 1'b1;
            r_dta   <= 1'b0;
          end else if (r_cnt == DT_W'(1)) begin
            r_state <= LS_ON;
            r_cnt   <= '0;
            r_l     <= 1'b1;
            r_dta   <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - DT_W'(1);
          end
        end
        default: begin
          r_state <= OFF;
          r_cnt   <= '0;
          r_h     <= 1'b0;
          r_l     <= 1'b0;
          r_dta   <= 1'b0;
        end
      endcase
    end
  end

  assign o_pwm_h     = r_h;
  assign o_pwm_l     = r_l;
  assign o_dt_active = r_dta;

endmodule

// File: rtl/dead_time_gen.sv
// Multi-channel complementary gate-drive generator with dead-time insertion.
// Optional feature macro: DEAD_TIME_ASYM_EN (separate rise/fall dead times).
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   EN, FAULT          global enable / bridge fault; either forces all channels OFF
//   PWM_IN[N_CH]       per-channel command, 1 = high side, 0 = low side
//   DT_CYCLES          shared dead time (macro undefined)
//   DT_RISE, DT_FALL   L->H and H->L dead times (macro defined)
//   PWM_H, PWM_L       registered gate drives per channel
//   DT_ACTIVE          registered, 1 while a channel is in a dead interval
module dead_time_gen
  import dead_time_pkg::*;
#(
  parameter int unsigned N_CH = 3,
  parameter int unsigned DT_W = DT_W_DEF
) (
  input  logic [0:0]      CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            FAULT,
  input  logic [N_CH-1:0] PWM_IN,
`ifdef DEAD_TIME_ASYM_EN
  input  logic [DT_W-1:0] DT_RISE,
  input  logic [DT_W-1:0] DT_FALL,
`else
  input  logic [DT_W-1:0] DT_CYCLES,
`endif
  output logic [N_CH-1:0] PWM_H,
  output logic [N_CH-1:0] PWM_L,
  output logic [N_CH-1:0] DT_ACTIVE
);

  if ((N_CH == 0) || (N_CH > N_CH_MAX)) begin : g_bad_n_ch
    $error("dead_time_gen: N_CH out of range");
  end

  logic [DT_W-1:0] w_dt_rise;
  logic [DT_W-1:0] w_dt_fall;

`ifdef DEAD_TIME_ASYM_EN
  assign w_dt_rise = DT_RISE;
  assign w_dt_fall = DT_FALL;
`else
  assign w_dt_rise = DT_CYCLES;
  assign w_dt_fall = DT_CYCLES;
`endif

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    dead_time_ch #(
      .DT_W (DT_W)
    ) u_ch (
      .i_clk       (CLK[0]),
      .i_rst       (RST),
      .i_en        (EN),
      .i_fault     (FAULT),
      .i_pwm       (PWM_IN[g]),
      .i_dt_rise   (w_dt_rise),
      .i_dt_fall   (w_dt_fall),
      .o_pwm_h     (PWM_H[g]),
      .o_pwm_l     (PWM_L[g]),
      .o_dt_active (DT_ACTIVE[g])
    );
  end

endmodule

// File: tb/tb_dead_time_gen.sv
// Self-checking bench for dead_time_gen: directed timing cases with literal
// expectations plus randomized stimulus compared every cycle to a
// behavioural model (side driven + remaining dead cycles per channel).
module tb_dead_time_gen;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         fault = 1'b0;
  logic [N-1:0] pwm = '0;
  logic [W-1:0] dt_r = '0;
  logic [W-1:0] dt_f = '0;
  logic [N-1:0] pwm_h, pwm_l, dt_act;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: side = -1 (nothing driven), 0 (low on), 1 (high on);
  // dead = remaining dead cycles; tgt = side being headed for.
  int m_side [N];
  int m_dead [N];
  int m_tgt  [N];

  always #5 clk = ~clk;

  dead_time_gen #(.N_CH(N), .DT_W(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .FAULT     (fault),
    .PWM_IN    (pwm),
`ifdef DEAD_TIME_ASYM_EN
    .DT_RISE   (dt_r),
    .DT_FALL   (dt_f),
`else
    .DT_CYCLES (dt_r),
`endif
    .PWM_H     (pwm_h),
    .PWM_L     (pwm_l),
    .DT_ACTIVE (dt_act)
  );

  task automatic chk(input string name, input int ch, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s ch%0d: got %0d, expected %0d at %0t", name, ch, act, exp, $time);
    end
  endtask

  task automatic set_dt(input int r, input int f);
`ifdef DEAD_TIME_ASYM_EN
    dt_r = W'(r);
    dt_f = W'(f);
`else
    dt_r = W'(r);
    dt_f = W'(r);
    if (f < 0) dt_f = '0;
`endif
  endtask

  function automatic int dead_for(input int dir);
    int d;
`ifdef DEAD_TIME_ASYM_EN
    d = (dir == 1) ? int'(dt_r) : int'(dt_f);
`else
    d = int'(dt_r);
`endif
    return (d < 1) ? 1 : d;
  endfunction

  // Reference model advances on each rising edge using the inputs it sees.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst || fault || !en) begin
        m_side[i] = -1;
        m_dead[i] = 0;
      end else if (m_dead[i] > 0) begin
        if (int'(pwm[i]) != m_tgt[i]) begin
          m_side[i] = int'(pwm[i]);
          m_dead[i] = 0;
        end else begin
          m_dead[i]--;
          if (m_dead[i] == 0) m_side[i] = m_tgt[i];
        end
      end else if (m_side[i] != int'(pwm[i])) begin
        m_tgt[i]  = int'(pwm[i]);
        m_dead[i] = dead_for(m_tgt[i]);
        m_side[i] = -1;
      end
    end
  end

  // Compare process: every output of every channel, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk("pwm_h", i, int'(pwm_h[i]), (m_dead[i] == 0 && m_side[i] == 1) ? 1 : 0);
        chk("pwm_l", i, int'(pwm_l[i]), (m_dead[i] == 0 && m_side[i] == 0) ? 1 : 0);
        chk("dt_active", i, int'(dt_act[i]), (m_dead[i] > 0) ? 1 : 0);
        chk("overlap", i, int'(pwm_h[i] & pwm_l[i]), 0);
      end
    end
  end

  // Count cycles with DT_ACTIVE[ch] high after inputs were driven at a negedge.
  task automatic dead_len(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (dt_act[ch]) n++;
      else return;
    end
    chk("dead_len_timeout", ch, n, -1);
  endtask

  initial begin
    int n, loff, hon;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_h", -1, int'(pwm_h), 0);
    chk("rst_l", -1, int'(pwm_l), 0);
    chk("rst_dta", -1, int'(dt_act), 0);
    rst = 1'b0;
    @(negedge clk);

    // Leaving OFF: full dead interval toward the low side.
    set_dt(5, 5);
    en  = 1'b1;
    pwm = '0;
    dead_len(0, n);
    chk("t1_dead", 0, n, 5);
    chk("t1_l", -1, int'(pwm_l), 7);
    chk("t1_h", -1, int'(pwm_h), 0);

    // L->H and H->L on channel 0.
    pwm[0] = 1'b1;
    dead_len(0, n);
    chk("t2_rise_dead", 0, n, 5);
    chk("t2_h", 0, int'(pwm_h[0]), 1);
    pwm[0] = 1'b0;
    dead_len(0, n);
    chk("t2_fall_dead", 0, n, 5);
    chk("t2_l", 0, int'(pwm_l[0]), 1);

    // Boundary dead times.
    set_dt(0, 0);
    pwm[0] = 1'b1;
    dead_len(0, n);
    chk("dt0_dead", 0, n, 1);
    set_dt(1, 1);
    pwm[0] = 1'b0;
    dead_len(0, n);
    chk("dt1_dead", 0, n, 1);
    set_dt(255, 255);
    pwm[0] = 1'b1;
    dead_len(0, n);
    chk("dt255_dead", 0, n, 255);

    // DT change mid-interval must not affect the interval in progress.
    set_dt(6, 6);
    pwm[0] = 1'b0;
    @(negedge clk);
    set_dt(1, 1);
    dead_len(0, n);
    chk("dt_change_dead", 0, n + 1, 6);

    // 3-cycle pulse shorter than the dead time is swallowed.
    set_dt(8, 8);
    loff = 0;
    hon  = 0;
    pwm[1] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 2) pwm[1] = 1'b0;
      if (!pwm_l[1]) loff++;
      if (pwm_h[1]) hon++;
    end
    chk("swallow_loff", 1, loff, 3);
    chk("swallow_hon", 1, hon, 0);

    // Fault from HS_ON, then recovery through a full dead interval.
    set_dt(4, 4);
    pwm = '1;
    dead_len(2, n);
    chk("all_hs_dead", 2, n, 4);
    chk("all_hs_h", -1, int'(pwm_h), 7);
    fault = 1'b1;
    @(negedge clk);
    chk("fault_h", -1, int'(pwm_h), 0);
    chk("fault_l", -1, int'(pwm_l), 0);
    chk("fault_dta", -1, int'(dt_act), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    fault = 1'b0;
    dead_len(2, n);
    chk("fault_recover_dead", 2, n, 4);
    chk("fault_recover_h", -1, int'(pwm_h), 7);

    // Enable drop from HS_ON, restart toward the low side.
    en = 1'b0;
    @(negedge clk);
    chk("en_off_h", -1, int'(pwm_h), 0);
    en  = 1'b1;
    pwm = '0;
    dead_len(1, n);
    chk("en_recover_dead", 1, n, 4);
    chk("en_recover_l", -1, int'(pwm_l), 7);

`ifdef DEAD_TIME_ASYM_EN
    set_dt(3, 7);
    pwm[0] = 1'b1;
    dead_len(0, n);
    chk("asym_rise", 0, n, 3);
    pwm[0] = 1'b0;
    dead_len(0, n);
    chk("asym_fall", 0, n, 7);
`endif

    // Randomized phase against the model.
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) pwm[i] = ~pwm[i];
      if ($urandom_range(0, 39) == 0)
        set_dt(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
      fault = ($urandom_range(0, 149) == 0);
      en    = ($urandom_range(0, 99) != 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
